conv_window_fetch: RTL and testbench

Upstream feeder for the 9-multiplier convolution datapath. Walks every valid 3x3 window of an H x W image held in the pixel ROM, drives the ROM address, and captures the returned pixels into a 9-tap window register. Presents each completed window to the multiplier array over a valid/ready handshake. The ROM is combinational (address in, data out in the same cycle), so the block registers `data` on the same edge it advances `adr`.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/win_addr_gen.sv | 96 +++++++++
 rtl/conv_window_fetch.sv | 141 ++++++++++++++
 tb/tb_conv_window_fetch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the 3x3 window fetcher
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } fetch_state_t;

  localparam int KSIZE = 3;
  localparam int TAPS  = KSIZE * KSIZE;
  localparam int TAP_W = $clog2(TAPS);

  localparam logic [1:0]       KPOS_LAST = 2'(KSIZE - 1);
  localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(TAPS - 1);

  // Row-major tap number k = 3*i + j, built from shifts and adds only
  function automatic logic [TAP_W-1:0] tap_index(input logic [1:0] i, input logic [1:0] j);
    return TAP_W'({i, 1'b0}) + TAP_W'(i) + TAP_W'(j);
  endfunction

endpackage

// File: rtl/win_addr_gen.sv
// rtl/win_addr_gen.sv - window/tap counters and incremental ROM address adders
module win_addr_gen
  import conv_pkg::*;
#(
  parameter int M  = 6,
  parameter int W  = 6,
  parameter int H  = 6,
  parameter int RW = $clog2(H),
  parameter int CW = $clog2(W)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic             i_advance,
  output logic [M-1:0]     o_adr,
  output logic [RW-1:0]    o_row,
  output logic [CW-1:0]    o_col,
  output logic [TAP_W-1:0] o_tap,
  output logic             o_last_tap,
  output logic             o_last_col,
  output logic             o_last_row
);

  localparam logic [M-1:0]  ROW_WRAP = M'(W - KSIZE + 1);
  localparam logic [M-1:0]  IMG_ROW  = M'(W);
  localparam logic [CW-1:0] C_LAST   = CW'(W - KSIZE);
  localparam logic [RW-1:0] R_LAST   = RW'(H - KSIZE);

  logic [RW-1:0] r_r;
  logic [CW-1:0] r_c;
  logic [1:0]    r_i;
  logic [1:0]    r_j;
  logic [M-1:0]  r_base;
  logic [M-1:0]  r_row_base;
  logic [M-1:0]  r_adr;

  logic          w_last_tap;
  logic          w_last_col;
  logic          w_last_row;
  logic [M-1:0]  w_next_col;
  logic [M-1:0]  w_next_row;

  assign w_last_tap = (r_i == KPOS_LAST) && (r_j == KPOS_LAST);
  assign w_last_col = (r_c == C_LAST);
  assign w_last_row = (r_r == R_LAST);
  assign w_next_col = r_base + M'(1);
  assign w_next_row = r_row_base + IMG_ROW;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_r        <= '0;
      r_c        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_base     <= '0;
      r_row_base <= '0;
      r_adr      <= '0;
    end else if (i_step) begin
      // Address drops back to 0 after the last tap so it idles low in HOLD
      if (w_last_tap) begin
        r_i   <= '0;
        r_j   <= '0;
        r_adr <= '0;
      end else if (r_j == KPOS_LAST) begin
        r_j   <= '0;
        r_i   <= r_i + 2'd1;
        r_adr <= r_adr + ROW_WRAP;
      end else begin
        r_j   <= r_j + 2'd1;
        r_adr <= r_adr + M'(1);
      end
    end else if (i_advance) begin
      if (!w_last_col) begin
        r_c    <= r_c + CW'(1);
        r_base <= w_next_col;
        r_adr  <= w_next_col;
      end else if (!w_last_row) begin
        r_c        <= '0;
        r_r        <= r_r + RW'(1);
        r_row_base <= w_next_row;
        r_base     <= w_next_row;
        r_adr      <= w_next_row;
      end
    end
  end

  assign o_adr      = r_adr;
  assign o_row      = r_r;
  assign o_col      = r_c;
  assign o_tap      = tap_index(r_i, r_j);
  assign o_last_tap = w_last_tap;
  assign o_last_col = w_last_col;
  assign o_last_row = w_last_row;

endmodule

// File: rtl/conv_window_fetch.sv
// rtl/conv_window_fetch.sv - walks all 3x3 windows of the pixel ROM and hands them out
module conv_window_fetch
  import conv_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 6,
  parameter int W = 6,
  parameter int H = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic [M-1:0]         o_adr,
  input  logic [N-1:0]         i_data,
  output logic [TAPS*N-1:0]    o_win,
  output logic                 o_win_valid,
  input  logic                 i_win_ready,
  output logic [$clog2(H)-1:0] o_win_row,
  output logic [$clog2(W)-1:0] o_win_col,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  if (W * H > (1 << M)) begin : g_err_adr
    $error("conv_window_fetch: image of W*H pixels does not fit in 2**M ROM words");
  end
  if (W < KSIZE || H < KSIZE) begin : g_err_dim
    $error("conv_window_fetch: image must be at least 3x3");
  end

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;

  logic [N-1:0]     r_taps [TAPS];
  logic [RW-1:0]    r_win_row;
  logic [CW-1:0]    r_win_col;

  logic             w_clear;
  logic             w_step;
  logic             w_advance;
  logic [RW-1:0]    w_row;
  logic [CW-1:0]    w_col;
  logic [TAP_W-1:0] w_tap;
  logic             w_last_tap;
  logic             w_last_col;
  logic             w_last_row;

  win_addr_gen #(
    .M (M),
    .W (W),
    .H (H),
    .RW(RW),
    .CW(CW)
  ) u_addr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_clear),
    .i_step    (w_step),
    .i_advance (w_advance),
    .o_adr     (o_adr),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_tap     (w_tap),
    .o_last_tap(w_last_tap),
    .o_last_col(w_last_col),
    .o_last_row(w_last_row)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_step      = 1'b0;
    w_advance   = 1'b0;
    o_win_valid = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_clear     = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_step = 1'b1;
        if (w_last_tap) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        o_win_valid = 1'b1;
        if (i_win_ready) begin
          w_advance   = 1'b1;
          w_state_nxt = (w_last_col && w_last_row) ? DONE : FETCH;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ROM is combinational, so the tap for the current address lands on this edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int t = 0; t < TAPS; t++) begin
        r_taps[t] <= '0;
      end
      r_win_row <= '0;
      r_win_col <= '0;
    end else if (w_step) begin
      r_taps[w_tap] <= i_data;
      if (w_last_tap && (w_tap == TAP_LAST)) begin
        r_win_row <= w_row;
        r_win_col <= w_col;
      end
    end
  end

  for (genvar t = 0; t < TAPS; t++) begin : g_win
    assign o_win[N*t +: N] = r_taps[t];
  end

  assign o_win_row = r_win_row;
  assign o_win_col = r_win_col;

endmodule

// File: tb/tb_conv_window_fetch.sv
// tb/tb_conv_window_fetch.sv - self-checking bench for conv_window_fetch on a 6x6 image
module tb_conv_window_fetch;

  localparam int N    = 8;
  localparam int M    = 6;
  localparam int W    = 6;
  localparam int H    = 6;
  localparam int NWIN = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [M-1:0]  adr;
  logic [N-1:0]  data;
  logic [71:0]   win;
  logic          win_valid;
  logic          win_ready;
  logic [2:0]    win_row;
  logic [2:0]    win_col;
  logic          busy;
  logic          done;

  logic [N-1:0]  rom [64];
  logic [71:0]   cap_win [NWIN];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int m_idx = 0;
  int m_fc  = 0;
  bit chk_en = 1'b0;

  conv_window_fetch #(.N(N), .M(M), .W(W), .H(H)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .o_adr      (adr),
    .i_data     (data),
    .o_win      (win),
    .o_win_valid(win_valid),
    .i_win_ready(win_ready),
    .o_win_row  (win_row),
    .o_win_col  (win_col),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int a = 0; a < 64; a++) rom[a] = N'(a + 1);
  end
  assign data = rom[adr];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%018h, expected 0x%018h", name, act, exp);
    end
  endtask

  // Window idx covers pixels (r+i, c+j); ROM word at (y, x) is y*W + x + 1
  function automatic logic [71:0] model_win(input int idx);
    logic [71:0] w;
    int r, c;
    r = idx / (W - 2);
    c = idx % (W - 2);
    w = '0;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'((r + k / 3) * W + c + k % 3 + 1);
    return w;
  endfunction

  function automatic int model_adr(input int idx, input int k);
    return (idx / (W - 2) + k / 3) * W + idx % (W - 2) + k % 3;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (win_valid) begin
        if (m_idx < NWIN) begin
          chk_w("win", win, model_win(m_idx));
          chk("win_row", int'(win_row), m_idx / (W - 2));
          chk("win_col", int'(win_col), m_idx % (W - 2));
          cap_win[m_idx] = win;
        end else begin
          chk("extra_window", m_idx, NWIN - 1);
        end
        chk("adr_in_hold", int'(adr), 0);
        chk("fetch_len", m_fc, 9);
        if (win_ready) begin
          m_idx++;
          m_fc = 0;
        end
      end else if (busy && !done) begin
        if (m_fc < 9 && m_idx < NWIN) chk("adr_fetch", int'(adr), model_adr(m_idx, m_fc));
        else chk("fetch_overrun", m_fc, 8);
        m_fc++;
      end else begin
        chk("adr_idle", int'(adr), 0);
        if (done) chk("done_after_all", m_idx, NWIN);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_adr", int'(adr), 0);
    chk_w("rst_win", win, 72'h0);
    chk("rst_valid", int'(win_valid), 0);
    chk("rst_row", int'(win_row), 0);
    chk("rst_col", int'(win_col), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
  endtask

  task automatic do_reset(input bit with_start);
    chk_en = 1'b0;
    rst    = 1'b1;
    start  = with_start;
    tick();
    tick();
    check_reset_vals();
    rst   = 1'b0;
    start = 1'b0;
    m_idx = 0;
    m_fc  = 0;
    chk_en = 1'b1;
  endtask

  task automatic start_pass(output int t0);
    m_idx = 0;
    m_fc  = 0;
    start = 1'b1;
    t0    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      if (win_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int t0;
    bit ok;
    rst       = 1'b1;
    start     = 1'b0;
    win_ready = 1'b0;

    // Reset, then one full pass with the consumer always ready
    do_reset(1'b0);
    win_ready = 1'b1;
    start_pass(t0);
    wait_valid(20, ok);
    chk("first_valid_seen", int'(ok), 1);
    chk("first_latency", cyc - t0, 10);
    chk_w("first_win_lit", win, 72'h0f0e0d090807030201);
    chk("first_row", int'(win_row), 0);
    chk("first_col", int'(win_col), 0);
    wait_done(300, ok);
    chk("done_seen", int'(ok), 1);
    chk("done_cycle", cyc - t0, 161);
    chk("busy_at_done", int'(busy), 1);
    tick();
    chk("done_single", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("win_count", m_idx, NWIN);
    chk_w("win5_lit", cap_win[4], 72'h1514130f0e0d090807);
    chk_w("win_last_lit", cap_win[NWIN-1], 72'h2423221e1d1c181716);

    // Stall window 2 for 20 cycles
    start_pass(t0);
    wait_valid(20, ok);
    chk("stall_w1_seen", int'(ok), 1);
    tick();
    win_ready = 1'b0;
    wait_valid(20, ok);
    chk("stall_w2_seen", int'(ok), 1);
    for (int s = 0; s < 20; s++) begin
      chk_w("stall_win", win, 72'h100f0e0a0908040302);
      chk("stall_adr", int'(adr), 0);
      chk("stall_valid", int'(win_valid), 1);
      tick();
    end
    win_ready = 1'b1;
    tick();
    chk("resume_valid", int'(win_valid), 0);
    chk("resume_busy", int'(busy), 1);
    chk("resume_adr", int'(adr), 2);
    wait_done(400, ok);
    chk("stall_done_seen", int'(ok), 1);
    chk("stall_count", m_idx, NWIN);
    tick();

    // Reset in the middle of window 3's fetch, with start high too
    start_pass(t0);
    while (cyc - t0 < 24) tick();
    chk("pre_rst_busy", int'(busy), 1);
    do_reset(1'b1);
    tick();
    chk("post_rst_idle", int'(busy), 0);
    start_pass(t0);
    wait_valid(20, ok);
    chk("restart_valid_seen", int'(ok), 1);
    chk("restart_latency", cyc - t0, 10);
    chk_w("restart_win_lit", win, 72'h0f0e0d090807030201);
    chk("restart_row", int'(win_row), 0);
    chk("restart_col", int'(win_col), 0);
    wait_done(300, ok);
    chk("restart_done_seen", int'(ok), 1);
    chk("restart_count", m_idx, NWIN);
    tick();

    // Stray start pulses while busy
    start_pass(t0);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      start = ((cyc - t0) % 7 == 3) && (cyc - t0 < 150);
      tick();
    end
    start = 1'b0;
    chk("pulse_done_seen", int'(ok), 1);
    chk("pulse_done_cycle", cyc - t0, 161);
    chk("pulse_count", m_idx, NWIN);
    tick();
    chk("pulse_idle", int'(busy), 0);

    // Random consumer backpressure
    win_ready = 1'b0;
    start_pass(t0);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      win_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rand_done_seen", int'(ok), 1);
    chk("rand_count", m_idx, NWIN);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog");
  end

endmodule
